// File: rtl/axi_fb_rdsub.sv
// AXI4 read-only framebuffer RAM subordinate; one 32-bit beat per cycle.
// Define AXI_FB_RDSUB_RANGE_CHK_EN to return SLVERR for beats beyond the RAM.
module axi_fb_rdsub #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MEM_WORDS  = 4096
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESET,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [7:0]                   S_AXI_ARLEN,
    input  logic [2:0]                   S_AXI_ARSIZE,
    input  logic [1:0]                   S_AXI_ARBURST,
    input  logic [ID_WIDTH-1:0]          S_AXI_ARID,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [31:0]                  S_AXI_RDATA,
    output logic                         S_AXI_RLAST,
    output logic [ID_WIDTH-1:0]          S_AXI_RID,
    output logic [1:0]                   S_AXI_RRESP,
    input  logic                         i_ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] i_ld_addr,
    input  logic [31:0]                  i_ld_data
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, BURST} state_e;

    state_e                state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            left_q, left_d;
    logic                  fixed_q, fixed_d;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  unused;

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge S_AXI_ACLK) begin
        if (i_ld_en) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        arready_d = (state_q == IDLE);
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        left_d    = left_q;
        fixed_d   = fixed_q;
        rd_en     = 1'b0;
        rd_addr   = addr_q;
        unique case (state_q)
            IDLE: begin
                // The first beat is read on the handshake edge itself.
                if (S_AXI_ARVALID && arready_q) begin
                    rd_en     = 1'b1;
                    rd_addr   = S_AXI_ARADDR;
                    state_d   = BURST;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (S_AXI_ARLEN == 8'd0);
                    rid_d     = S_AXI_ARID;
                    left_d    = S_AXI_ARLEN;
                    fixed_d   = (S_AXI_ARBURST == 2'b00);
                    addr_d    = fixed_d ? S_AXI_ARADDR
                                        : S_AXI_ARADDR + ADDR_WIDTH'(4);
                end
            end
            BURST: begin
                if (!rvalid_q || S_AXI_RREADY) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        rd_en    = 1'b1;
                        rvalid_d = 1'b1;
                        rlast_d  = (left_q == 8'd1);
                        left_d   = left_q - 8'd1;
                        addr_d   = fixed_q ? addr_q
                                           : addr_q + ADDR_WIDTH'(4);
                    end
                end
            end
        endcase
        if (rd_en) begin
            rdata_d = mem[rd_addr[IW+1:2]];
            rresp_d = 2'b00;
`ifdef AXI_FB_RDSUB_RANGE_CHK_EN
            if ((rd_addr >> (IW + 2)) != '0) begin
                rdata_d = 32'd0;
                rresp_d = 2'b10;
            end
`endif
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rid_q     <= '0;
            rresp_q   <= 2'b00;
            addr_q    <= '0;
            left_q    <= 8'd0;
            fixed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            fixed_q   <= fixed_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RRESP   = rresp_q;

    // Beats are always 32-bit, so size and byte lanes carry no information.
    assign unused = ^{S_AXI_ARSIZE, rd_addr};
endmodule

// File: tb/tb_axi_fb_rdsub.sv
// Bench for axi_fb_rdsub: queue-based burst model plus literal spot checks.
// Honours AXI_FB_RDSUB_RANGE_CHK_EN when defined for the build.
module tb_axi_fb_rdsub;
    localparam int MW = 64;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        id;
        logic [1:0]  resp;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic [0:0]  arid = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic        rlast;
    logic [0:0]  rid;
    logic [1:0]  rresp;
    logic        ld_en = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    int    vectors = 0;
    int    errs = 0;
    logic  live = 1'b0;
    logic [31:0] mm [MW];
    beat_t q[$];
    beat_t lg[$];

    axi_fb_rdsub #(.ADDR_WIDTH(32), .ID_WIDTH(1), .MEM_WORDS(MW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARID(arid), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata),
        .S_AXI_RLAST(rlast), .S_AXI_RID(rid), .S_AXI_RRESP(rresp),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else live <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_burst(input logic [31:0] a,
                                       input logic [7:0] len,
                                       input logic [1:0] bt,
                                       input logic id);
        for (int b = 0; b <= int'(len); b++) begin
            beat_t e;
            logic [32:0] ba;
            ba = (bt == 2'b00) ? {1'b0, a} : {1'b0, a} + 33'(4 * b);
            e.last = (b == int'(len));
            e.id = id;
            e.data = mm[int'(ba / 4) % MW];
            e.resp = 2'b00;
`ifdef AXI_FB_RDSUB_RANGE_CHK_EN
            if (ba >= 33'(MW * 4)) begin
                e.data = 32'd0;
                e.resp = 2'b10;
            end
`endif
            q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_arready", 32'(arready), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_rlast", 32'(rlast), 32'd0);
            chk("rst_rid", 32'(rid), 32'd0);
            chk("rst_rresp", 32'(rresp), 32'd0);
            q.delete();
        end else begin
            chk("arready", 32'(arready), 32'(live && q.size() == 0));
            chk("rvalid", 32'(rvalid), 32'(q.size() != 0));
            if (rvalid && q.size() != 0) begin
                chk("rdata", rdata, q[0].data);
                chk("rlast", 32'(rlast), 32'(q[0].last));
                chk("rid", 32'(rid), 32'(q[0].id));
                chk("rresp", 32'(rresp), 32'(q[0].resp));
                if (rready) begin
                    beat_t g;
                    g.data = rdata;
                    g.last = rlast;
                    g.id = rid[0];
                    g.resp = rresp;
                    lg.push_back(g);
                    void'(q.pop_front());
                end
            end
            if (arvalid && arready) push_burst(araddr, arlen, arburst, arid[0]);
        end
    end

    task automatic load(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1;
        ld_addr = 6'(a);
        ld_data = d;
        mm[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic ar_hs(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt, input logic id);
        int n;
        @(posedge clk); #1;
        araddr = a;
        arlen = len;
        arburst = bt;
        arid = id;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic burst(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt, input logic id,
                         input logic [3:0] pat);
        int k;
        lg.delete();
        ar_hs(a, len, bt, id);
        k = 0;
        for (int c = 0; c < 1200 && lg.size() < int'(len) + 1; c++) begin
            rready = pat[k % 4];
            k++;
            @(posedge clk); #1;
        end
        chk("burst_len", 32'(lg.size()), 32'(int'(len) + 1));
        rready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mm[i] = 32'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("arready_post_reset", 32'(arready), 32'd1);

        for (int i = 0; i < MW; i++) load(i, (i < 16) ? 32'h100 + 32'(i) : 32'h0);
        load(MW - 2, 32'hAAA0);
        load(MW - 1, 32'hAAA1);

        burst(32'h0, 8'd7, 2'b01, 1'b0, 4'b1111);
        chk("incr_b0", lg[0].data, 32'h100);
        chk("incr_b7", lg[7].data, 32'h107);
        chk("incr_last7", 32'(lg[7].last), 32'd1);
        chk("incr_last6", 32'(lg[6].last), 32'd0);

        burst(32'h8, 8'd3, 2'b00, 1'b1, 4'b1111);
        chk("fixed_b0", lg[0].data, 32'h102);
        chk("fixed_b3", lg[3].data, 32'h102);
        chk("fixed_id", 32'(lg[3].id), 32'd1);

        burst(32'((MW - 2) * 4), 8'd3, 2'b01, 1'b0, 4'b1111);
        chk("edge_b1", lg[1].data, 32'hAAA1);
`ifdef AXI_FB_RDSUB_RANGE_CHK_EN
        chk("edge_b2", lg[2].data, 32'h0);
        chk("edge_resp2", 32'(lg[2].resp), 32'd2);
        chk("edge_resp3", 32'(lg[3].resp), 32'd2);
`else
        chk("edge_b2", lg[2].data, 32'h100);
        chk("edge_b3", lg[3].data, 32'h101);
        chk("edge_resp3", 32'(lg[3].resp), 32'd0);
`endif

        burst(32'(MW * 4 + 4), 8'd0, 2'b01, 1'b0, 4'b1111);
`ifdef AXI_FB_RDSUB_RANGE_CHK_EN
        chk("upper_resp", 32'(lg[0].resp), 32'd2);
`else
        chk("upper_data", lg[0].data, 32'h101);
`endif
        chk("single_last", 32'(lg[0].last), 32'd1);

        burst(32'h10, 8'd3, 2'b01, 1'b1, 4'b1001);
        chk("stall_b1", lg[1].data, 32'h105);
        chk("stall_b3", lg[3].data, 32'h107);

        burst(32'h10, 8'd2, 2'b10, 1'b0, 4'b1111);
        chk("wrap_b2", lg[2].data, 32'h106);

        lg.delete();
        @(posedge clk); #1;
        araddr = 32'h14;
        arlen = 8'd0;
        arburst = 2'b01;
        arid = 1'b0;
        arvalid = 1'b1;
        ld_en = 1'b1;
        ld_addr = 6'd5;
        ld_data = 32'hBEEF;
        @(negedge clk);
        chk("old_ar_ready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        ld_en = 1'b0;
        mm[5] = 32'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("old_data", lg.size() > 0 ? lg[0].data : 32'hDEAD, 32'h105);
        burst(32'h14, 8'd0, 2'b00, 1'b0, 4'b1111);
        chk("new_data", lg[0].data, 32'hBEEF);

        burst(32'h0, 8'd255, 2'b01, 1'b0, 4'b1111);
        chk("long_last", 32'(lg[255].last), 32'd1);
        chk("long_b64", lg[64].data, 32'h100);

        lg.delete();
        ar_hs(32'h0, 8'd15, 2'b01, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_arready", 32'(arready), 32'd1);
        burst(32'h20, 8'd1, 2'b01, 1'b0, 4'b1111);
        chk("post_rst_b0", lg[0].data, 32'h108);
        chk("post_rst_b1", lg[1].data, 32'h109);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
